// File: rtl/pwm_pkg.sv
// Shared types and threshold encoding for the multi-channel PWM scheduler.
package pwm_pkg;

  localparam int CBITS_DEF = 19;
  localparam int DBITS_DEF = 4;

  typedef logic [DBITS_DEF-1:0] duty_t;

  typedef enum logic {
    CH_IDLE,
    CH_PENDING
  } chan_state_e;

  // {1'b0, duty, 1'b1, zeros}: odd multiple of the LSB step, so never 0 and
  // always below half the period.
  function automatic logic [31:0] duty_to_thresh(input logic [15:0] duty,
                                                 input int cbits,
                                                 input int dbits);
    return (({16'd0, duty} << 1) | 32'd1) << (cbits - dbits - 2);
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: pending/active duty slots, boundary commit and comparator.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int CBITS = CBITS_DEF,
  parameter int DBITS = DBITS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CBITS-1:0] cnt,
  input  logic             boundary,
  input  logic             wr,
  input  logic [DBITS-1:0] wr_duty,
  input  logic             en,
  output logic             pending_vld,
  output logic             pwm_out
);

  chan_state_e      state, state_nxt;
  logic [DBITS-1:0] active;
  logic [DBITS-1:0] pending;
  logic [CBITS-1:0] thresh;

  assign thresh      = CBITS'(duty_to_thresh(16'(active), CBITS, DBITS));
  assign pending_vld = (state == CH_PENDING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CH_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CH_IDLE:    if (wr) state_nxt = CH_PENDING;
      CH_PENDING: if (boundary) state_nxt = CH_IDLE;
      default:    state_nxt = CH_IDLE;
    endcase
  end

  // Commit happens before a same-cycle accept lands, so a boundary write waits a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= '0;
      pending <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (boundary && pending_vld) active <= pending;
      if (wr) pending <= wr_duty;
      pwm_out <= en && (cnt < thresh);
    end
  end

endmodule

// File: rtl/pwm_chan_scheduler.sv
// Shared period counter, boundary decode and update-port demux feeding NCH PWM channels.
module pwm_chan_scheduler
  import pwm_pkg::*;
#(
  parameter int CBITS = CBITS_DEF,
  parameter int DBITS = DBITS_DEF,
  parameter int NCH   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   upd_valid,
  input  logic [$clog2(NCH)-1:0] upd_ch,
  input  logic [DBITS-1:0]       upd_duty,
  output logic                   upd_ready,
  input  logic [NCH-1:0]         en,
  output logic [NCH-1:0]         pwm_out,
  output logic                   period_start
);

  localparam int CHW = $clog2(NCH);

  logic [CBITS-1:0] cnt;
  logic             boundary;
  logic [NCH-1:0]   pending_vld;
  logic [NCH-1:0]   wr;
  logic             ch_legal;
  logic             ch_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  assign boundary     = &cnt;
  assign period_start = (cnt == '0);

  always_comb begin
    ch_busy = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (upd_ch == CHW'(i)) ch_busy = pending_vld[i];
    end
    ch_legal  = (int'(upd_ch) < NCH);
    upd_ready = upd_valid ? (ch_legal && !ch_busy) : 1'b1;
  end

  always_comb begin
    wr = '0;
    for (int i = 0; i < NCH; i++) begin
      wr[i] = upd_valid && upd_ready && (upd_ch == CHW'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    pwm_chan #(
      .CBITS(CBITS),
      .DBITS(DBITS)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt        (cnt),
      .boundary   (boundary),
      .wr         (wr[g]),
      .wr_duty    (upd_duty),
      .en         (en[g]),
      .pending_vld(pending_vld[g]),
      .pwm_out    (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_chan_scheduler.sv
// Bench for pwm_chan_scheduler at CBITS=8, DBITS=4, NCH=3 (period 256, thresh = 8d+4).
module tb_pwm_chan_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       upd_valid;
  logic [1:0] upd_ch;
  logic [3:0] upd_duty;
  logic       upd_ready;
  logic [2:0] en;
  logic [2:0] pwm_out;
  logic       period_start;

  int checks = 0;
  int errors = 0;
  int width[3];
  int ps_count;

  // Reference model: period position, per-channel duty slots, expected outputs.
  int       m_cnt;
  int       m_act[3];
  int       m_pend[3];
  bit [2:0] m_pvld;
  logic [2:0] m_pwm;
  logic     exp_rdy;

  pwm_chan_scheduler #(.CBITS(8), .DBITS(4), .NCH(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .upd_valid   (upd_valid),
    .upd_ch      (upd_ch),
    .upd_duty    (upd_duty),
    .upd_ready   (upd_ready),
    .en          (en),
    .pwm_out     (pwm_out),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_pvld <= '0;
      m_pwm  <= '0;
      for (int i = 0; i < 3; i++) begin
        m_act[i]  <= 0;
        m_pend[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_pwm[i] <= en[i] && (m_cnt < 8 * m_act[i] + 4);
        if (m_cnt == 255 && m_pvld[i]) begin
          m_act[i]  <= m_pend[i];
          m_pvld[i] <= 1'b0;
        end
        if (upd_valid && int'(upd_ch) == i && !m_pvld[i]) begin
          m_pend[i] <= int'(upd_duty);
          m_pvld[i] <= 1'b1;
        end
      end
      m_cnt <= (m_cnt + 1) % 256;
    end
  end

  always @(negedge clk) begin
    exp_rdy = upd_valid ? ((upd_ch < 2'd3) ? !m_pvld[upd_ch] : 1'b0) : 1'b1;
    checks++;
    if (pwm_out !== m_pwm) begin
      errors++;
      $display("FAIL monitor_pwm cnt=%0d got %b want %b", m_cnt, pwm_out, m_pwm);
    end
    checks++;
    if (period_start !== (m_cnt == 0)) begin
      errors++;
      $display("FAIL monitor_period_start cnt=%0d got %b want %b", m_cnt, period_start, (m_cnt == 0));
    end
    checks++;
    if (upd_ready !== exp_rdy) begin
      errors++;
      $display("FAIL monitor_upd_ready ch=%0d got %b want %b", upd_ch, upd_ready, exp_rdy);
    end
  end

  task automatic wait_cnt(input int v);
    int n = 0;
    while (m_cnt != v && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (m_cnt != v) begin
      errors++;
      $display("FAIL wait_cnt timeout got %0d want %0d", m_cnt, v);
    end
  endtask

  task automatic measure();
    wait_cnt(1);
    ps_count = 0;
    for (int i = 0; i < 3; i++) width[i] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) width[i] += int'(pwm_out[i]);
      ps_count += int'(period_start);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; upd_valid = 1'b0; upd_ch = 2'd0; upd_duty = 4'd0; en = 3'b000;
    #3;
    checks++;
    if (pwm_out !== 3'b000) begin errors++; $display("FAIL reset_pwm got %b want 000", pwm_out); end
    checks++;
    if (upd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", upd_ready); end
    en = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (period_start !== 1'b1) begin errors++; $display("FAIL first_period_start got %b want 1", period_start); end
    @(posedge clk); #1;
    repeat (2) begin
      measure();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (width[i] != 4) begin errors++; $display("FAIL reset_width ch%0d got %0d want 4", i, width[i]); end
      end
      checks++;
      if (ps_count != 1) begin errors++; $display("FAIL period_start_count got %0d want 1", ps_count); end
    end
  endtask

  task automatic test_update_ch1();
    wait_cnt(100);
    upd_valid = 1'b1; upd_ch = 2'd1; upd_duty = 4'd15;
    #1;
    checks++;
    if (upd_ready !== 1'b1) begin errors++; $display("FAIL ch1_ready got %b want 1", upd_ready); end
    @(posedge clk); #1;
    upd_valid = 1'b0;
    measure();
    checks++;
    if (width[0] != 4 || width[1] != 124 || width[2] != 4) begin
      errors++;
      $display("FAIL ch1_update widths got %0d/%0d/%0d want 4/124/4", width[0], width[1], width[2]);
    end
  endtask

  task automatic test_ch2_stall();
    int n = 0;
    wait_cnt(10);
    upd_valid = 1'b1; upd_ch = 2'd2; upd_duty = 4'd3;
    #1;
    checks++;
    if (upd_ready !== 1'b1) begin errors++; $display("FAIL ch2_first_ready got %b want 1", upd_ready); end
    @(posedge clk); #1;
    upd_duty = 4'd7;
    #1;
    checks++;
    if (upd_ready !== 1'b0) begin errors++; $display("FAIL ch2_stall_ready got %b want 0", upd_ready); end
    while (upd_ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (upd_ready !== 1'b1 || period_start !== 1'b1) begin
      errors++;
      $display("FAIL ch2_release got ready=%b period_start=%b want 1/1", upd_ready, period_start);
    end
    @(posedge clk); #1;
    upd_valid = 1'b0;
    measure();
    checks++;
    if (width[0] != 4 || width[1] != 124 || width[2] != 28) begin
      errors++;
      $display("FAIL ch2_period1 widths got %0d/%0d/%0d want 4/124/28", width[0], width[1], width[2]);
    end
    measure();
    checks++;
    if (width[0] != 4 || width[1] != 124 || width[2] != 60) begin
      errors++;
      $display("FAIL ch2_period2 widths got %0d/%0d/%0d want 4/124/60", width[0], width[1], width[2]);
    end
  endtask

  task automatic test_boundary_update();
    wait_cnt(255);
    upd_valid = 1'b1; upd_ch = 2'd0; upd_duty = 4'd9;
    #1;
    checks++;
    if (upd_ready !== 1'b1) begin errors++; $display("FAIL boundary_ready got %b want 1", upd_ready); end
    @(posedge clk); #1;
    upd_valid = 1'b0;
    measure();
    checks++;
    if (width[0] != 4) begin errors++; $display("FAIL boundary_hold ch0 got %0d want 4", width[0]); end
    measure();
    checks++;
    if (width[0] != 76) begin errors++; $display("FAIL boundary_commit ch0 got %0d want 76", width[0]); end
  endtask

  task automatic test_enable();
    wait_cnt(2);
    en = 3'b101;
    @(posedge clk); #1;
    checks++;
    if (pwm_out !== 3'b101) begin errors++; $display("FAIL en_off got %b want 101", pwm_out); end
    wait_cnt(50);
    en = 3'b111;
    @(posedge clk); #1;
    checks++;
    if (pwm_out[1] !== 1'b1) begin errors++; $display("FAIL en_on_below got %b want 1", pwm_out[1]); end
    wait_cnt(130);
    en = 3'b101;
    wait_cnt(200);
    en = 3'b111;
    @(posedge clk); #1;
    checks++;
    if (pwm_out[1] !== 1'b0) begin errors++; $display("FAIL en_on_above got %b want 0", pwm_out[1]); end
  endtask

  task automatic test_reset_mid();
    wait_cnt(40);
    upd_valid = 1'b1; upd_ch = 2'd1; upd_duty = 4'd5;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    wait_cnt(50);
    #2;
    checks++;
    if (pwm_out !== 3'b111) begin errors++; $display("FAIL pre_reset_pwm got %b want 111", pwm_out); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== 3'b000) begin errors++; $display("FAIL async_reset_pwm got %b want 000", pwm_out); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    upd_valid = 1'b1; upd_ch = 2'd3; upd_duty = 4'd12;
    #1;
    checks++;
    if (upd_ready !== 1'b0) begin errors++; $display("FAIL illegal_ready got %b want 0", upd_ready); end
    repeat (3) begin @(posedge clk); #1; end
    upd_valid = 1'b0;
    repeat (2) begin
      measure();
      checks++;
      if (width[0] != 4 || width[1] != 4 || width[2] != 4) begin
        errors++;
        $display("FAIL post_reset widths got %0d/%0d/%0d want 4/4/4", width[0], width[1], width[2]);
      end
    end
  endtask

  task automatic test_random();
    repeat (3000) begin
      @(posedge clk); #1;
      upd_valid = ($urandom % 3) == 0;
      upd_ch    = 2'($urandom);
      upd_duty  = 4'($urandom);
      if ($urandom % 64 == 0) en = 3'($urandom);
    end
    @(posedge clk); #1;
    upd_valid = 1'b0;
    en = 3'b111;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_update_ch1();
    test_ch2_stall();
    test_boundary_update();
    test_enable();
    test_reset_mid();
    test_illegal();
    test_random();
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
